// File: rtl/phoenix_local_ni_pkg.sv
// Shared definitions for the Phoenix local-port network interface:
// flit width default, injection FSM states and ejection parser phases.
package phoenix_local_ni_pkg;

    localparam int TAM_FLIT_DEF = 16;
    localparam int RX_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_SIZE    = 2'd2,
        S_PAYLOAD = 2'd3
    } inj_state_t;

    typedef enum logic [1:0] {
        E_HEADER  = 2'd0,
        E_SIZE    = 2'd1,
        E_PAYLOAD = 2'd2
    } ej_phase_t;

endpackage

// File: rtl/phoenix_local_ni_fifo.sv
// First-word fall-through FIFO for ejected flits tagged with {sop, eop}.
// Pointers carry one extra wrap bit so full and empty need no separate counter.
module ni_flit_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign dout = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/phoenix_local_ni.sv
// Phoenix router local-port NI: packetizes host requests into header/size/payload
// flits toward the router and de-packetizes ejected flits into a FWFT host stream.
import phoenix_local_ni_pkg::*;

module phoenix_local_ni #(
    parameter int TAM_FLIT = TAM_FLIT_DEF,
    parameter int RX_DEPTH = RX_DEPTH_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pkt_valid,
    input  logic [TAM_FLIT-1:0] pkt_target,
    input  logic [TAM_FLIT-1:0] pkt_size,
    output logic                pkt_ready,
    input  logic                pay_valid,
    input  logic [TAM_FLIT-1:0] pay_data,
    output logic                pay_ready,
    output logic                rx_o,
    output logic [TAM_FLIT-1:0] data_o,
    input  logic                credit_i,
    input  logic                tx_i,
    input  logic [TAM_FLIT-1:0] data_i,
    output logic                credit_o,
    output logic                rcv_valid,
    output logic [TAM_FLIT-1:0] rcv_data,
    output logic                rcv_sop,
    output logic                rcv_eop,
    input  logic                rcv_ready,
    output logic [15:0]         pkt_count
);

    inj_state_t          r_state;
    logic [TAM_FLIT-1:0] r_target;
    logic [TAM_FLIT-1:0] r_size;
    logic [TAM_FLIT-1:0] r_remaining;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_size      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pkt_valid) begin
                        r_target <= pkt_target;
                        r_size   <= pkt_size;
                        r_state  <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (credit_i) begin
                        r_state <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    if (credit_i) begin
                        if (r_size == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_remaining <= r_size;
                            r_state     <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (pay_valid && credit_i) begin
                        r_remaining <= r_remaining - TAM_FLIT'(1);
                        if (r_remaining == TAM_FLIT'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Payload flits pass straight through so a flit is forwarded the cycle the host offers it.
    always_comb begin
        pkt_ready = 1'b0;
        pay_ready = 1'b0;
        rx_o      = 1'b0;
        data_o    = '0;
        case (r_state)
            S_IDLE: begin
                pkt_ready = 1'b1;
            end
            S_HEADER: begin
                rx_o   = 1'b1;
                data_o = r_target;
            end
            S_SIZE: begin
                rx_o   = 1'b1;
                data_o = r_size;
            end
            S_PAYLOAD: begin
                rx_o      = pay_valid;
                data_o    = pay_data;
                pay_ready = credit_i;
            end
            default: ;
        endcase
    end

    ej_phase_t           r_phase;
    logic [TAM_FLIT-1:0] r_ej_remaining;
    logic [15:0]         r_pkt_count;
    logic                w_push;
    logic                w_pop;
    logic                w_push_sop;
    logic                w_push_eop;
    logic                w_full;
    logic                w_empty;
    logic [TAM_FLIT+1:0] w_fifo_dout;

    assign credit_o = !w_full;
    assign w_push   = tx_i && credit_o;
    assign w_pop    = rcv_valid && rcv_ready;

    always_comb begin
        w_push_sop = 1'b0;
        w_push_eop = 1'b0;
        case (r_phase)
            E_HEADER:  w_push_sop = 1'b1;
            E_SIZE:    w_push_eop = (data_i == '0);
            E_PAYLOAD: w_push_eop = (r_ej_remaining == TAM_FLIT'(1));
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase        <= E_HEADER;
            r_ej_remaining <= '0;
            r_pkt_count    <= '0;
        end else if (w_push) begin
            case (r_phase)
                E_HEADER: begin
                    r_phase <= E_SIZE;
                end
                E_SIZE: begin
                    r_ej_remaining <= data_i;
                    r_phase        <= (data_i == '0) ? E_HEADER : E_PAYLOAD;
                end
                E_PAYLOAD: begin
                    r_ej_remaining <= r_ej_remaining - TAM_FLIT'(1);
                    if (r_ej_remaining == TAM_FLIT'(1)) begin
                        r_phase <= E_HEADER;
                    end
                end
                default: r_phase <= E_HEADER;
            endcase
            if (w_push_eop) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    ni_flit_fifo #(
        .WIDTH (TAM_FLIT + 2),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .din   ({w_push_sop, w_push_eop, data_i}),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Storage is not reset, so the marks are qualified by valid.
    assign rcv_valid = !w_empty;
    assign rcv_data  = w_fifo_dout[TAM_FLIT-1:0];
    assign rcv_sop   = w_fifo_dout[TAM_FLIT+1] && !w_empty;
    assign rcv_eop   = w_fifo_dout[TAM_FLIT] && !w_empty;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_phoenix_local_ni.sv
// Scoreboard bench for phoenix_local_ni: expected injected flits and ejected
// {sop,eop,data} words are queued at stimulus time and compared as the DUT emits them.
module tb_phoenix_local_ni;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid, pay_valid, credit_i, tx_i, rcv_ready;
    logic [15:0] pkt_target, pkt_size, pay_data, data_i;
    logic        pkt_ready, pay_ready, rx_o, credit_o, rcv_valid, rcv_sop, rcv_eop;
    logic [15:0] data_o, rcv_data, pkt_count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          xfer_cnt = 0;
    int          rx_cycles = 0;
    logic [15:0] inj_q [$];
    logic [17:0] ej_q [$];
    logic [15:0] pay_buf [8];
    logic [15:0] ej_buf [8];

    always #5 clock = ~clock;

    phoenix_local_ni #(.TAM_FLIT(16), .RX_DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .pkt_valid  (pkt_valid),
        .pkt_target (pkt_target),
        .pkt_size   (pkt_size),
        .pkt_ready  (pkt_ready),
        .pay_valid  (pay_valid),
        .pay_data   (pay_data),
        .pay_ready  (pay_ready),
        .rx_o       (rx_o),
        .data_o     (data_o),
        .credit_i   (credit_i),
        .tx_i       (tx_i),
        .data_i     (data_i),
        .credit_o   (credit_o),
        .rcv_valid  (rcv_valid),
        .rcv_data   (rcv_data),
        .rcv_sop    (rcv_sop),
        .rcv_eop    (rcv_eop),
        .rcv_ready  (rcv_ready),
        .pkt_count  (pkt_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (rx_o) rx_cycles++;
            if (rx_o && credit_i) begin
                xfer_cnt++;
                if (inj_q.size() == 0) chk("inj_extra_flit", 32'(data_o), 32'hFFFF_FFFF);
                else chk("inj_flit", 32'(data_o), 32'(inj_q.pop_front()));
            end
            if (rcv_valid && rcv_ready) begin
                if (ej_q.size() == 0) chk("ej_extra_flit", 32'({rcv_sop, rcv_eop, rcv_data}), 32'hFFFF_FFFF);
                else chk("ej_flit", 32'({rcv_sop, rcv_eop, rcv_data}), 32'(ej_q.pop_front()));
            end
        end
    end

    task automatic inject(input logic [15:0] tgt, input logic [15:0] sz, input int n);
        int   guard;
        logic ok;
        guard = 0;
        while (!pkt_ready && guard < 100) begin
            @(posedge clock); #1; guard++;
        end
        inj_q.push_back(tgt);
        inj_q.push_back(sz);
        for (int i = 0; i < n; i++) inj_q.push_back(pay_buf[i]);
        pkt_valid = 1'b1; pkt_target = tgt; pkt_size = sz;
        @(posedge clock); #1;
        pkt_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            pay_valid = 1'b1; pay_data = pay_buf[i];
            ok = 1'b0; guard = 0;
            while (!ok && guard < 200) begin
                @(negedge clock); ok = pay_ready;
                @(posedge clock); #1; guard++;
            end
            chk("pay_accept", 32'(ok), 32'd1);
        end
        pay_valid = 1'b0;
        guard = 0;
        while (!pkt_ready && guard < 100) begin
            @(posedge clock); #1; guard++;
        end
        chk("pkt_ready_return", 32'(pkt_ready), 32'd1);
    endtask

    task automatic send_eject(input int n);
        int   guard;
        logic ok;
        logic sop, eop;
        for (int i = 0; i < n; i++) begin
            sop = (i == 0);
            eop = (i == 1 && ej_buf[1] == 16'h0) || (i >= 2 && i == n - 1);
            ej_q.push_back({sop, eop, ej_buf[i]});
        end
        for (int i = 0; i < n; i++) begin
            tx_i = 1'b1; data_i = ej_buf[i];
            ok = 1'b0; guard = 0;
            while (!ok && guard < 200) begin
                @(negedge clock); ok = credit_o;
                @(posedge clock); #1; guard++;
            end
            chk("ej_accept", 32'(ok), 32'd1);
        end
        tx_i = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (ej_q.size() != 0 && guard < 200) begin
            @(posedge clock); #1; guard++;
        end
        chk("ej_drained", 32'(ej_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, r0, guard;
        pkt_valid = 0; pkt_target = 0; pkt_size = 0; pay_valid = 0; pay_data = 0;
        credit_i = 1; tx_i = 0; data_i = 0; rcv_ready = 0;

        #12;
        chk("rst_pkt_ready", 32'(pkt_ready), 32'd1);
        chk("rst_rx_o", 32'(rx_o), 32'd0);
        chk("rst_pay_ready", 32'(pay_ready), 32'd0);
        chk("rst_credit_o", 32'(credit_o), 32'd1);
        chk("rst_rcv_valid", 32'(rcv_valid), 32'd0);
        chk("rst_rcv_sop", 32'(rcv_sop), 32'd0);
        chk("rst_rcv_eop", 32'(rcv_eop), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        // Plain 3-flit payload at full credit
        pay_buf[0] = 16'h00A1; pay_buf[1] = 16'h00A2; pay_buf[2] = 16'h00A3;
        x0 = xfer_cnt; r0 = rx_cycles;
        inject(16'h0101, 16'h0003, 3);
        chk("t1_xfers", 32'(xfer_cnt - x0), 32'd5);
        chk("t1_rx_cycles", 32'(rx_cycles - r0), 32'd5);

        // Credit withdrawn while the size flit is on the link
        x0 = xfer_cnt;
        fork
            inject(16'h0101, 16'h0003, 3);
            begin
                guard = 0;
                do begin
                    @(negedge clock); guard++;
                end while (!(rx_o && data_o == 16'h0101) && guard < 50);
                @(posedge clock); #1 credit_i = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    chk("t2_size_hold", 32'(data_o), 32'h0003);
                    chk("t2_rx_hold", 32'(rx_o), 32'd1);
                end
                @(posedge clock); #1 credit_i = 1'b1;
            end
        join
        chk("t2_xfers", 32'(xfer_cnt - x0), 32'd5);

        // Zero-size packet both directions
        x0 = xfer_cnt;
        inject(16'h0202, 16'h0000, 0);
        chk("t3_xfers", 32'(xfer_cnt - x0), 32'd2);
        rcv_ready = 1'b1;
        ej_buf[0] = 16'h0202; ej_buf[1] = 16'h0000;
        send_eject(2);
        wait_drain();
        @(negedge clock);
        chk("t3_pkt_count", 32'(pkt_count), 32'd1);

        // Back-pressure: FIFO fills, credit drops, then drains in order
        @(posedge clock); #1 rcv_ready = 1'b0;
        ej_buf[0] = 16'h0101; ej_buf[1] = 16'h0004;
        ej_buf[2] = 16'h00B1; ej_buf[3] = 16'h00B2; ej_buf[4] = 16'h00B3; ej_buf[5] = 16'h00B4;
        fork
            send_eject(6);
            begin
                repeat (4) @(negedge clock);
                chk("t4_credit_before_full", 32'(credit_o), 32'd1);
                @(negedge clock);
                chk("t4_credit_full", 32'(credit_o), 32'd0);
                repeat (3) @(negedge clock);
                chk("t4_credit_held", 32'(credit_o), 32'd0);
                chk("t4_head_sop", 32'(rcv_sop), 32'd1);
                chk("t4_head_data", 32'(rcv_data), 32'h0101);
                @(posedge clock); #1 rcv_ready = 1'b1;
            end
        join
        wait_drain();
        @(negedge clock);
        chk("t4_pkt_count", 32'(pkt_count), 32'd2);
        chk("t4_rcv_valid_empty", 32'(rcv_valid), 32'd0);

        // Asynchronous reset in the middle of a payload
        @(posedge clock); #1 rcv_ready = 1'b0;
        inj_q.push_back(16'h0303); inj_q.push_back(16'h0005);
        pkt_valid = 1'b1; pkt_target = 16'h0303; pkt_size = 16'h0005;
        @(posedge clock); #1 pkt_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        credit_i = 1'b0; pay_valid = 1'b1; pay_data = 16'h00C1;
        tx_i = 1'b1; data_i = 16'h0303;
        @(posedge clock); #1 data_i = 16'h0005;
        @(posedge clock); #1 tx_i = 1'b0;
        @(negedge clock);
        chk("t5_pre_rx_o", 32'(rx_o), 32'd1);
        chk("t5_pre_rcv_valid", 32'(rcv_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rx_o", 32'(rx_o), 32'd0);
        chk("t5_pkt_ready", 32'(pkt_ready), 32'd1);
        chk("t5_pay_ready", 32'(pay_ready), 32'd0);
        chk("t5_credit_o", 32'(credit_o), 32'd1);
        chk("t5_rcv_valid", 32'(rcv_valid), 32'd0);
        chk("t5_pkt_count", 32'(pkt_count), 32'd0);
        chk("t5_inj_q", 32'(inj_q.size()), 32'd0);
        pay_valid = 1'b0; credit_i = 1'b1;
        @(posedge clock); #1 reset = 1'b0;

        // Clean traffic after reset
        pay_buf[0] = 16'h00C5;
        inject(16'h0404, 16'h0001, 1);
        rcv_ready = 1'b1;
        ej_buf[0] = 16'h0404; ej_buf[1] = 16'h0001; ej_buf[2] = 16'h00C5;
        send_eject(3);
        wait_drain();
        @(negedge clock);
        chk("t6_pkt_count", 32'(pkt_count), 32'd1);

        repeat (3) @(posedge clock);
        chk("end_inj_q", 32'(inj_q.size()), 32'd0);
        chk("end_ej_q", 32'(ej_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
